// File: rtl/ps2_cmd_ctrl_if.sv
// Bundle between the PS/2 command controller, its host and the PS/2 byte transmitter/receiver.
// master = host plus PHY side; slave = the command controller.
// Valid/ready on the command path; tx/rx strobes are single-cycle pulses.
interface ps2_cmd_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_byte;
    logic       cmd_has_arg;
    logic [7:0] cmd_arg;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_done;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       key_valid;
    logic [7:0] key_byte;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    modport master (
        output cmd_valid, cmd_byte, cmd_has_arg, cmd_arg, tx_done, rx_valid, rx_byte,
        input  cmd_ready, tx_start, tx_byte, key_valid, key_byte, done, err, err_code
    );

    modport slave (
        input  cmd_valid, cmd_byte, cmd_has_arg, cmd_arg, tx_done, rx_valid, rx_byte,
        output cmd_ready, tx_start, tx_byte, key_valid, key_byte, done, err, err_code
    );
endinterface

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 host command sequencer: sends cmd (+arg), waits for 0xFA/0xFE, resends, forwards scan codes.
// Latency: all outputs registered, one cycle after the causing input; ACK timeout under PS2_CMD_CTRL_TIMEOUT_EN.
// Backpressure: cmd_ready only in IDLE; rx bytes are never stalled (forwarded or consumed every cycle).
module ps2_cmd_ctrl #(
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int MAX_RETRY      = 2
) (
    input logic           clk,
    input logic           rst_n,
    ps2_cmd_ctrl_if.slave bus
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    if (TIMEOUT_CYCLES < 2) begin : g_tmo_param_chk
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX_CMD  = 3'd1,
        ACK_CMD = 3'd2,
        TX_ARG  = 3'd3,
        ACK_ARG = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    cmd_q, arg_q;
    logic          has_arg_q;
    logic [RW-1:0] retry_cnt, retry_nxt;
    logic          cmd_ready_q, tx_start_q, key_valid_q, done_q, err_q;
    logic [7:0]    tx_byte_q, key_byte_q;
    logic [1:0]    err_code_q, err_code_nxt;
    logic          accept, done_nxt, err_nxt, key_valid_nxt, tx_start_nxt;
    logic          in_ack, rx_ack, rx_resend, tmo_hit;

    assign in_ack    = (state == ACK_CMD) || (state == ACK_ARG);
    assign rx_ack    = bus.rx_valid && (bus.rx_byte == 8'hFA);
    assign rx_resend = bus.rx_valid && (bus.rx_byte == 8'hFE);

`ifdef PS2_CMD_CTRL_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_cnt;

    // ACK states are never entered back-to-back, so clearing outside them restarts at 0 on entry
    always_ff @(posedge clk) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (!in_ack)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = in_ack && (tmo_cnt == TW'(TIMEOUT_CYCLES - 2));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        retry_nxt     = retry_cnt;
        err_code_nxt  = err_code_q;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        accept        = 1'b0;
        key_valid_nxt = bus.rx_valid && !(in_ack && (rx_ack || rx_resend));

        case (state)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    accept       = 1'b1;
                    retry_nxt    = '0;
                    err_code_nxt = 2'b00;
                    state_nxt    = TX_CMD;
                end
            end
            TX_CMD: begin
                if (bus.tx_done && !tx_start_q)
                    state_nxt = ACK_CMD;
            end
            TX_ARG: begin
                if (bus.tx_done && !tx_start_q)
                    state_nxt = ACK_ARG;
            end
            ACK_CMD, ACK_ARG: begin
                if (rx_ack) begin
                    if ((state == ACK_CMD) && has_arg_q) begin
                        state_nxt = TX_ARG;
                        retry_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else if (rx_resend) begin
                    if (retry_cnt < RW'(MAX_RETRY)) begin
                        retry_nxt = retry_cnt + 1'b1;
                        state_nxt = (state == ACK_CMD) ? TX_CMD : TX_ARG;
                    end else begin
                        state_nxt    = IDLE;
                        err_nxt      = 1'b1;
                        err_code_nxt = 2'b01;
                    end
                end else if (tmo_hit) begin
                    state_nxt    = IDLE;
                    err_nxt      = 1'b1;
                    err_code_nxt = 2'b10;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Every TX entry is a state change, including resends from an ACK state
        tx_start_nxt = ((state_nxt == TX_CMD) && (state != TX_CMD)) ||
                       ((state_nxt == TX_ARG) && (state != TX_ARG));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retry_cnt   <= '0;
            err_code_q  <= 2'b00;
            cmd_ready_q <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_byte_q   <= 8'h00;
            key_valid_q <= 1'b0;
            key_byte_q  <= 8'h00;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_q       <= 8'h00;
            arg_q       <= 8'h00;
            has_arg_q   <= 1'b0;
        end else begin
            retry_cnt   <= retry_nxt;
            err_code_q  <= err_code_nxt;
            cmd_ready_q <= (state_nxt == IDLE);
            tx_start_q  <= tx_start_nxt;
            key_valid_q <= key_valid_nxt;
            done_q      <= done_nxt;
            err_q       <= err_nxt;
            if (key_valid_nxt)
                key_byte_q <= bus.rx_byte;
            if (accept) begin
                cmd_q     <= bus.cmd_byte;
                arg_q     <= bus.cmd_arg;
                has_arg_q <= bus.cmd_has_arg;
            end
            // On accept the command byte is not latched yet, so take it straight from the bus
            if (tx_start_nxt)
                tx_byte_q <= (state_nxt == TX_ARG) ? arg_q : (accept ? bus.cmd_byte : cmd_q);
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_byte   = tx_byte_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_byte  = key_byte_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Bench for ps2_cmd_ctrl: scoreboard of expected output events (tx_start, key, done, err) popped on negedge.
// Build with PS2_CMD_CTRL_TIMEOUT_EN to exercise the ACK timeout path.
module tb_ps2_cmd_ctrl;
    localparam logic [1:0] K_TX = 2'd0, K_KEY = 2'd1, K_DONE = 2'd2, K_ERR = 2'd3;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [9:0] exp_q[$];

    ps2_cmd_ctrl_if bus ();

    ps2_cmd_ctrl #(
        .TIMEOUT_CYCLES(16),
        .MAX_RETRY     (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [7:0] dat);
        exp_q.push_back({kind, dat});
    endtask

    task automatic sb_pop(input string tag, input logic [9:0] got);
        logic [9:0] e;
        if (exp_q.size() == 0) begin
            $display("note: unexpected %s event, data=0x%02h", tag, got[7:0]);
            check({tag, "_unexpected"}, exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            check(tag, got, e);
        end
    endtask

    // Output monitor: every pulse must match the next queued expectation
    always @(negedge clk) begin
        if (bus.tx_start)  sb_pop("tx_start", {K_TX, bus.tx_byte});
        if (bus.key_valid) sb_pop("key",      {K_KEY, bus.key_byte});
        if (bus.done)      sb_pop("done",     {K_DONE, 8'h00});
        if (bus.err)       sb_pop("err",      {K_ERR, 6'b0, bus.err_code});
        if (bus.done || bus.err)
            check("done_err_excl", bus.done & bus.err, 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic has_arg, input logic [7:0] a);
        int w = 0;
        while (!bus.cmd_ready && w < 50) begin
            tick();
            w++;
        end
        if (!bus.cmd_ready)
            check("cmd_ready_wait", bus.cmd_ready, 1);
        bus.cmd_valid   = 1'b1;
        bus.cmd_byte    = c;
        bus.cmd_has_arg = has_arg;
        bus.cmd_arg     = a;
        tick();
        bus.cmd_valid   = 1'b0;
    endtask

    task automatic pulse_tx_done();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_cmd_ready"}, bus.cmd_ready, 0);
        check({pfx, "_tx_start"},  bus.tx_start,  0);
        check({pfx, "_tx_byte"},   bus.tx_byte,   8'h00);
        check({pfx, "_key_valid"}, bus.key_valid, 0);
        check({pfx, "_key_byte"},  bus.key_byte,  8'h00);
        check({pfx, "_done"},      bus.done,      0);
        check({pfx, "_err"},       bus.err,       0);
        check({pfx, "_err_code"},  bus.err_code,  2'b00);
    endtask

    initial begin
        int n;
        bus.cmd_valid   = 1'b0;
        bus.cmd_byte    = 8'h00;
        bus.cmd_has_arg = 1'b0;
        bus.cmd_arg     = 8'h00;
        bus.tx_done     = 1'b0;
        bus.rx_valid    = 1'b0;
        bus.rx_byte     = 8'h00;
        rst_n           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", bus.cmd_ready, 1);

        // 0xED + 0x02; tx_done during tx_start cycle must be ignored; 0xFA in TX state is a key byte
        expect_ev(K_TX, 8'hED);
        send_cmd(8'hED, 1'b1, 8'h02);
        check("ed_tx_byte", bus.tx_byte, 8'hED);
        check("ed_busy", bus.cmd_ready, 0);
        pulse_tx_done();
        check("ed_tx_byte_hold", bus.tx_byte, 8'hED);
        expect_ev(K_KEY, 8'hFA);
        rx(8'hFA);
        pulse_tx_done();
        expect_ev(K_TX, 8'h02);
        rx(8'hFA);
        tick();
        check("arg_tx_byte", bus.tx_byte, 8'h02);
        pulse_tx_done();
        expect_ev(K_DONE, 8'h00);
        rx(8'hFA);
        tick();
        check("ed_ready_after", bus.cmd_ready, 1);
        check("ed_err_code", bus.err_code, 2'b00);

        // 0xFF: two resends then ACK
        expect_ev(K_TX, 8'hFF);
        send_cmd(8'hFF, 1'b0, 8'h00);
        tick();
        pulse_tx_done();
        for (int i = 0; i < 2; i++) begin
            expect_ev(K_TX, 8'hFF);
            rx(8'hFE);
            tick();
            pulse_tx_done();
        end
        expect_ev(K_DONE, 8'h00);
        rx(8'hFA);
        tick();

        // 0xFF: third resend exhausts retries
        expect_ev(K_TX, 8'hFF);
        send_cmd(8'hFF, 1'b0, 8'h00);
        tick();
        pulse_tx_done();
        for (int i = 0; i < 2; i++) begin
            expect_ev(K_TX, 8'hFF);
            rx(8'hFE);
            tick();
            pulse_tx_done();
        end
        expect_ev(K_ERR, 8'h01);
        rx(8'hFE);
        check("retry_err_code", bus.err_code, 2'b01);
        repeat (3) tick();
        check("retry_err_code_hold", bus.err_code, 2'b01);
        check("retry_ready", bus.cmd_ready, 1);

        // Scan code inside ACK_CMD is forwarded; 0xFA/0xFE in IDLE are forwarded
        expect_ev(K_TX, 8'hF5);
        send_cmd(8'hF5, 1'b0, 8'h00);
        check("err_code_cleared", bus.err_code, 2'b00);
        tick();
        pulse_tx_done();
        expect_ev(K_KEY, 8'h1C);
        rx(8'h1C);
        expect_ev(K_DONE, 8'h00);
        rx(8'hFA);
        tick();
        expect_ev(K_KEY, 8'hFA);
        rx(8'hFA);
        expect_ev(K_KEY, 8'hFE);
        rx(8'hFE);
        tick();

        // rx and tx_done together in TX_CMD, then reset in TX_ARG
        expect_ev(K_TX, 8'hED);
        send_cmd(8'hED, 1'b1, 8'h02);
        tick();
        expect_ev(K_KEY, 8'h55);
        bus.tx_done  = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_byte  = 8'h55;
        tick();
        bus.tx_done  = 1'b0;
        bus.rx_valid = 1'b0;
        expect_ev(K_TX, 8'h02);
        rx(8'hFA);
        tick();
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        tick();
        check("midrst_ready", bus.cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_no_done", bus.done, 0);
            check("midrst_no_err", bus.err, 0);
        end

`ifdef PS2_CMD_CTRL_TIMEOUT_EN
        // No response: err 15 cycles after ACK_CMD entry
        expect_ev(K_TX, 8'hF4);
        send_cmd(8'hF4, 1'b0, 8'h00);
        tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        expect_ev(K_ERR, 8'h02);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.err) begin
                n = i;
                break;
            end
        end
        check("tmo_latency", n, 15);
        check("tmo_err_code", bus.err_code, 2'b10);
`else
        // Without the timeout the ACK wait is unbounded
        expect_ev(K_TX, 8'hF4);
        send_cmd(8'hF4, 1'b0, 8'h00);
        tick();
        pulse_tx_done();
        n = 0;
        repeat (100) begin
            tick();
            if (bus.err) n++;
        end
        check("no_tmo_err", n, 0);
        check("no_tmo_busy", bus.cmd_ready, 0);
        expect_ev(K_DONE, 8'h00);
        rx(8'hFA);
        check("no_tmo_err_code", bus.err_code, 2'b00);
`endif

        repeat (5) tick();
        check("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
